// File: rtl/ipv_expander.sv
// ipv_expander: serializes MSB-aligned thermometer vectors into K-cycle bursts, MSB first,
// with a one-deep hold register so consecutive bursts chain without idle cycles.
module ipv_expander #(
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [K-1:0] vov_in,
  input  logic         vov_valid,
  output logic         vov_ready,
  output logic         ipv_out,
  output logic         out_valid,
  output logic         err,
  output logic         busy
);
  logic         r_shift;
  logic         r_hold_full;
  logic         r_err;
  logic [K-1:0] r_sh;
  logic [K-1:0] r_hold;
  logic [2:0]   r_cnt;
  logic         w_xfer;
  logic         w_last;
  logic         w_legal;
  logic [K-1:0] w_inv;

  assign vov_ready = ~r_hold_full;
  assign w_xfer    = vov_valid & vov_ready;
  assign w_last    = r_cnt == 3'(K-1);
  // Legal codes have an inverse of the form 0..01..1, i.e. inverse+1 shares no set bit with it.
  assign w_inv     = ~vov_in;
  assign w_legal   = (w_inv & (w_inv + K'(1))) == '0;
  // The shift register is cleared on entering IDLE, so its MSB is already 0 whenever out_valid is 0.
  assign ipv_out   = r_sh[K-1];
  assign out_valid = r_shift;
  assign err       = r_err;
  assign busy      = r_shift | r_hold_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift     <= 1'b0;
      r_hold_full <= 1'b0;
      r_err       <= 1'b0;
      r_sh        <= '0;
      r_hold      <= '0;
      r_cnt       <= '0;
    end else begin
      r_err <= w_xfer & ~w_legal;
      if (!r_shift) begin
        if (w_xfer) begin
          r_sh    <= vov_in;
          r_cnt   <= '0;
          r_shift <= 1'b1;
        end
      end else if (!w_last) begin
        r_sh  <= r_sh << 1;
        r_cnt <= r_cnt + 3'd1;
        if (w_xfer) begin
          r_hold      <= vov_in;
          r_hold_full <= 1'b1;
        end
      end else if (r_hold_full) begin
        r_sh        <= r_hold;
        r_hold_full <= 1'b0;
        r_cnt       <= '0;
      end else if (w_xfer) begin
        r_sh  <= vov_in;
        r_cnt <= '0;
      end else begin
        r_sh    <= '0;
        r_cnt   <= '0;
        r_shift <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ipv_expander.sv
// tb_ipv_expander: scoreboard bench; expected bits, err pulses and round-trip vectors are queued
// at each transfer and consumed as the serial stream appears.
module tb_ipv_expander;
  localparam int K = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [K-1:0] vov_in = '0;
  logic         vov_valid = 1'b0;
  logic         vov_ready, ipv_out, out_valid, err, busy;

  int           n_vec = 0;
  int           n_bad = 0;
  bit           bit_q[$];
  logic [K-1:0] vec_q[$];
  logic         err_pend = 1'b0;
  logic [K-1:0] acc = '0;
  int           nacc = 0;

  ipv_expander #(.K(K)) dut (
    .clk(clk), .rst_n(rst_n), .vov_in(vov_in), .vov_valid(vov_valid), .vov_ready(vov_ready),
    .ipv_out(ipv_out), .out_valid(out_valid), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic legal(input logic [K-1:0] v);
    logic [K-1:0] t;
    t = '0;
    legal = (v == t);
    for (int n = 1; n <= K; n++) begin
      t[K-n] = 1'b1;
      if (v == t) legal = 1'b1;
    end
  endfunction

  // Monitor plus serial-reducer model; inputs are stable here for the coming rising edge.
  always @(negedge clk) begin
    chk("err", err, err_pend);
    if (!out_valid) chk("ipv_zero", ipv_out, 0);
    if (bit_q.size() == 0) chk("idle_ov", out_valid, 0);
    else begin
      chk("gap", out_valid, 1);
      if (out_valid) begin
        chk("bit", ipv_out, bit_q.pop_front());
        acc = {acc[K-2:0], ipv_out};
        nacc++;
        if (nacc == K) begin
          chk("loop", acc, vec_q.pop_front());
          nacc = 0;
        end
      end
    end
    err_pend = 1'b0;
    if (rst_n && vov_valid && vov_ready) begin
      err_pend = !legal(vov_in);
      vec_q.push_back(vov_in);
      for (int i = K-1; i >= 0; i--) bit_q.push_back(vov_in[i]);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [K-1:0] v);
    vov_in = v;
    vov_valid = 1'b1;
    for (int i = 0; ; i++) begin
      @(negedge clk);
      if (vov_ready) break;
      if (i > 50) begin
        chk("ready_timeout", vov_ready, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [K-1:0] codes [5];
    codes = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111};
    #3;
    chk("rst_ready", vov_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_ipv", ipv_out, 0);
    chk("rst_err", err, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(4'b1100);
    vov_valid = 1'b0;
    cyc(6);
    chk("single_idle", busy, 0);
    send(4'b1110);
    send(4'b1000);
    vov_valid = 1'b0;
    chk("hold_ready", vov_ready, 0);
    chk("hold_busy", busy, 1);
    cyc(2);
    chk("hold_ready_last", vov_ready, 0);
    cyc(1);
    chk("hold_drained", vov_ready, 1);
    cyc(8);
    send(4'b0000);
    vov_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("byp_ready", vov_ready, 1);
    end
    @(posedge clk);
    #1;
    send(4'b1111);
    vov_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("byp_ready2", vov_ready, 1);
    end
    cyc(4);
    send(4'b0101);
    vov_valid = 1'b0;
    @(negedge clk);
    chk("err_pulse", err, 1);
    cyc(6);
    send(4'b1111);
    send(4'b1100);
    vov_valid = 1'b0;
    #2 rst_n = 1'b0;
    bit_q.delete();
    vec_q.delete();
    err_pend = 1'b0;
    nacc = 0;
    #1;
    chk("mid_rst_ov", out_valid, 0);
    chk("mid_rst_ipv", ipv_out, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", vov_ready, 1);
    cyc(2);
    rst_n = 1'b1;
    cyc(8);
    chk("post_rst_busy", busy, 0);
    foreach (codes[i]) send(codes[i]);
    vov_valid = 1'b0;
    cyc(30);
    for (int i = 0; i < 20; i++) begin
      send(K'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        vov_valid = 1'b0;
        cyc($urandom_range(0, 5));
      end
    end
    vov_valid = 1'b0;
    cyc(40);
    chk("drain_q", bit_q.size(), 0);
    chk("drain_busy", busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time %0t exceeded limit 100000", $time);
    $fatal(1);
  end
endmodule

// File: doc/ipv_expander.md
IPV_EXPANDER -- requirements
Module: ipv_expander

Interface
REQ-001 Parameter: K, default 4, vector width and burst length in cycles; legal range 2..8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 vov_in  input  K  parallel vector to serialize; MSB-aligned thermometer code expected.
REQ-005 vov_valid  input  1  vov_in holds a vector offered for transfer.
REQ-006 vov_ready  output  1  block can accept a vector this cycle.
REQ-007 ipv_out  output  1  serial bit, MSB of the vector first.
REQ-008 out_valid  output  1  ipv_out carries a burst bit this cycle.
REQ-009 err  output  1  one-cycle pulse: accepted vector was not a legal thermometer code.
REQ-010 busy  output  1  a burst is in progress or a vector is held pending.

Function
REQ-011 Transfer occurs at a rising edge where vov_valid and vov_ready are both 1; vov_in is sampled at that edge only.
REQ-012 Storage: one K-bit shift register (active burst), one K-bit hold register with full flag (pending), one 3-bit bit counter.
REQ-013 vov_ready = NOT hold_full (combinational from registered state); independent of vov_valid.
REQ-014 States: IDLE (out_valid=0, shift register empty), SHIFT (burst active).
REQ-015 IDLE + transfer at edge E -> load shift register, counter=0, enter SHIFT; bits vov_in[K-1], [K-2], ..., [0] drive ipv_out in cycles E+1 .. E+K with out_valid=1 (latency 1 cycle).
REQ-016 ipv_out and out_valid are registered outputs; ipv_out=0 whenever out_valid=0.
REQ-017 Every burst is exactly K contiguous cycles of out_valid=1; no gaps inside a burst.
REQ-018 SHIFT, counter < K-1 -> shift left one bit, counter+1; a transfer in this state writes the hold register and sets hold_full.
REQ-019 SHIFT, counter = K-1 (last bit), hold_full=1 -> load hold into shift register, clear hold_full, counter=0; next burst starts with no idle cycle.
REQ-020 SHIFT, counter = K-1, hold_full=0, transfer this edge -> vov_in loads directly into shift register (bypasses hold), counter=0, stay SHIFT.
REQ-021 SHIFT, counter = K-1, hold_full=0, no transfer -> enter IDLE; out_valid=0 next cycle.
REQ-022 Last-bit edge with hold_full=1: vov_ready=0, so no transfer; hold is drained and vov_ready becomes 1 the following cycle.
REQ-023 Legal code: vov_in equals n ones in bits [K-1:K-n] and zeros below, n = 0..K.
REQ-024 Illegal code accepted: err=1 in the cycle after the transfer edge; vector still serialized bit-for-bit unmodified.
REQ-025 Counter wraps K-1 -> 0 only via REQ-019/020/021; never exceeds K-1.
REQ-026 busy = (state = SHIFT) OR hold_full.
REQ-027 Round-trip: a legal vector serialized here and fed as ipv_in/in_valid to the existing serial reducer reproduces the same vector.

Reset
REQ-028 rst_n low asynchronously forces: state IDLE, shift register 0, hold 0, hold_full 0, counter 0, ipv_out 0, out_valid 0, err 0; hence vov_ready=1, busy=0.
REQ-029 Reset mid-burst or with hold full discards all in-flight and pending data; no partial burst resumes after release.
REQ-030 First transfer allowed at the first rising edge after rst_n deasserts.

Verification (K=4)
REQ-031 Single vector: vov_in=4'b1100 accepted from IDLE at edge E -> ipv_out 1,1,0,0 in cycles E+1..E+4, out_valid=1 exactly 4 cycles, err=0, then IDLE.
REQ-032 Back-to-back: 4'b1110 then 4'b1000 offered continuously -> second goes to hold; 8 contiguous out_valid cycles emitting 1,1,1,0,1,0,0,0; vov_ready=0 while hold full.
REQ-033 Bypass: 4'b1111 accepted in last-bit cycle of burst 4'b0000 with hold empty -> 0,0,0,0,1,1,1,1 with no gap, hold_full never set.
REQ-034 Illegal code: vov_in=4'b0101 accepted -> err=1 for one cycle after transfer; ipv_out 0,1,0,1.
REQ-035 Reset mid-burst: rst_n low during 2nd bit of 4'b1111 with hold holding 4'b1100 -> out_valid, ipv_out, busy 0 immediately; vov_ready=1; no bits emitted after release until new transfer.
REQ-036 Loopback: all 5 legal codes 0000..1111 through this block into the serial reducer -> reducer vector equals input for each.
